// File: rtl/video_timing_gen_if.sv
// Raster timing bundle shared by the timing source and the TMDS encoders.
interface video_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic          pixel_stb;
  logic          window;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output pixel_stb, window, hsync, vsync, x, y, line_start, frame_start
  );

  modport slave (
    input pixel_stb, window, hsync, vsync, x, y, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing source: pixel strobe divider, h/v counters and registered
// zero-latency decode of window, syncs, coordinates and start pulses.
module video_timing_gen #(
  parameter int unsigned CLK_DIV  = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 12
) (
  input  logic               clk,
  input  logic               reset,
  video_timing_gen_if.master vid_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // run_q is low for the reset state; the first edge out of reset loads
  // pixel (0,0) with div_cnt=0 so cycle 0 already presents the first pixel.
  logic          run_q,  run_d;
  logic [DW-1:0] div_q,  div_d;
  logic [CW-1:0] h_q,    h_d;
  logic [CW-1:0] v_q,    v_d;
  logic          stb_q,  stb_d;
  logic          win_q,  win_d;
  logic          hs_q,   hs_d;
  logic          vs_q,   vs_d;
  logic          ls_q,   ls_d;
  logic          fs_q,   fs_d;

  // Next counter state and decode of the pixel that will be in force next.
  always_comb begin
    run_d = 1'b1;
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!run_q) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      if (div_q == DW'(CLK_DIV - 1)) div_d = '0;
      else                           div_d = div_q + DW'(1);
      if (stb_q) begin
        if (h_q == CW'(H_TOTAL - 1)) begin
          h_d = '0;
          if (v_q == CW'(V_TOTAL - 1)) v_d = '0;
          else                         v_d = v_q + CW'(1);
        end else begin
          h_d = h_q + CW'(1);
        end
      end
    end
    stb_d = (div_d == DW'(CLK_DIV - 1));
    win_d = (h_d < CW'(H_ACTIVE)) && (v_d < CW'(V_ACTIVE));
    hs_d  = ((h_d >= CW'(HS_START)) && (h_d < CW'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d  = ((v_d >= CW'(VS_START)) && (v_d < CW'(VS_END))) ? VS_POL : ~VS_POL;
    ls_d  = stb_d && (h_d == '0);
    fs_d  = ls_d && (v_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      stb_q <= 1'b0;
      win_q <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      stb_q <= stb_d;
      win_q <= win_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign vid_o.pixel_stb   = stb_q;
  assign vid_o.window      = win_q;
  assign vid_o.hsync       = hs_q;
  assign vid_o.vsync       = vs_q;
  assign vid_o.x           = h_q;
  assign vid_o.y           = v_q;
  assign vid_o.line_start  = ls_q;
  assign vid_o.frame_start = fs_q;

endmodule
